// File: rtl/stage_if_prefetch.sv
// Instruction-fetch prefetch stage: icache lookup, byte-serial miss refill,
// 2-bit BHT / JAL next-pc prediction, and a circular instruction queue.
module stage_if_prefetch #(
  parameter int unsigned QDEPTH   = 4,
  parameter int unsigned BHT_NUM  = 128,
  parameter int unsigned PRED_EN  = 1,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [31:0]                flush_addr_i,
  input  logic                       bht_upd_i,
  input  logic [31:0]                bht_upd_pc_i,
  input  logic                       bht_upd_taken_i,
  output logic [31:0]                icache_raddr_o,
  input  logic                       icache_hit_i,
  input  logic [31:0]                icache_inst_i,
  output logic                       icache_we_o,
  output logic [31:0]                icache_waddr_o,
  output logic [31:0]                icache_winst_o,
  output logic                       mem_req_o,
  output logic [31:0]                mem_a_o,
  input  logic                       mem_gnt_i,
  input  logic [7:0]                 mem_din_i,
  input  logic                       deq_i,
  output logic                       valid_o,
  output logic [31:0]                inst_o,
  output logic [31:0]                pc_o,
  output logic                       pred_taken_o,
  output logic [$clog2(QDEPTH):0]    count_o
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = $clog2(BHT_NUM);

  typedef enum logic [1:0] {IDLE, LOOKUP, MEM, DONE} state_t;
  state_t state, state_nxt;

  logic [31:0]   fpc;
  logic [1:0]    k;
  logic          pend;
  logic [23:0]   bytes;
  logic [1:0]    bht [0:BHT_NUM-1];
  logic [1:0]    bht_ctr;
  logic [31:0]   q_inst [0:QDEPTH-1];
  logic [31:0]   q_pc   [0:QDEPTH-1];
  logic          q_pred [0:QDEPTH-1];
  logic [PW-1:0] head, tail;
  logic          not_full, push, pop, pred;
  logic [31:0]   fill_word, fetch_inst, next_fpc, b_imm, j_imm;
  logic          unused_upd_bits;

  assign unused_upd_bits = ^{bht_upd_pc_i[31:BW+2], bht_upd_pc_i[1:0]};

  assign not_full   = (count_o != CW'(QDEPTH));
  assign fill_word  = {mem_din_i, bytes};
  assign fetch_inst = (state == DONE) ? fill_word : icache_inst_i;
  assign push       = !flush_i && ((state == LOOKUP && icache_hit_i) || state == DONE);
  assign pop        = !flush_i && deq_i && (count_o != '0);
  assign bht_ctr    = bht[fpc[BW+1:2]];

  assign valid_o      = (count_o != '0);
  assign inst_o       = valid_o ? q_inst[head] : '0;
  assign pc_o         = valid_o ? q_pc[head]   : '0;
  assign pred_taken_o = valid_o ? q_pred[head] : 1'b0;

  always_comb begin
    b_imm    = {{20{fetch_inst[31]}}, fetch_inst[7], fetch_inst[30:25], fetch_inst[11:8], 1'b0};
    j_imm    = {{12{fetch_inst[31]}}, fetch_inst[19:12], fetch_inst[20], fetch_inst[30:21], 1'b0};
    next_fpc = fpc + 32'd4;
    pred     = 1'b0;
    if (PRED_EN != 0) begin
      if (fetch_inst[6:0] == 7'b1100011 && bht_ctr[1]) begin
        next_fpc = fpc + b_imm;
        pred     = 1'b1;
      end else if (fetch_inst[6:0] == 7'b1101111) begin
        next_fpc = fpc + j_imm;
        pred     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (not_full) state_nxt = LOOKUP;
        LOOKUP:  state_nxt = icache_hit_i ? IDLE : MEM;
        MEM:     if (mem_gnt_i && k == 2'd3) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Granted bytes land one cycle later; shifting them in keeps {b2,b1,b0}
  // ordered, and b3 is taken straight off the bus in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc            <= RESET_PC;
      icache_raddr_o <= '0;
      icache_we_o    <= 1'b0;
      icache_waddr_o <= '0;
      icache_winst_o <= '0;
      mem_req_o      <= 1'b0;
      mem_a_o        <= '0;
      k              <= '0;
      pend           <= 1'b0;
      bytes          <= '0;
    end else begin
      icache_we_o <= 1'b0;
      if (flush_i) begin
        fpc       <= flush_addr_i;
        mem_req_o <= 1'b0;
        pend      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (not_full) icache_raddr_o <= fpc;
          LOOKUP: begin
            if (icache_hit_i) begin
              fpc <= next_fpc;
            end else begin
              mem_req_o <= 1'b1;
              mem_a_o   <= fpc;
              k         <= '0;
              pend      <= 1'b0;
            end
          end
          MEM: begin
            if (pend) bytes <= {mem_din_i, bytes[23:8]};
            pend <= mem_gnt_i;
            if (mem_gnt_i) begin
              if (k == 2'd3) begin
                mem_req_o <= 1'b0;
              end else begin
                k       <= k + 2'd1;
                mem_a_o <= mem_a_o + 32'd1;
              end
            end
          end
          DONE: begin
            icache_we_o    <= 1'b1;
            icache_waddr_o <= fpc;
            icache_winst_o <= fill_word;
            fpc            <= next_fpc;
            pend           <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < BHT_NUM; i++) bht[i] <= 2'b01;
    end else if (bht_upd_i) begin
      if (bht_upd_taken_i) begin
        if (bht[bht_upd_pc_i[BW+1:2]] != 2'b11)
          bht[bht_upd_pc_i[BW+1:2]] <= bht[bht_upd_pc_i[BW+1:2]] + 2'b01;
      end else begin
        if (bht[bht_upd_pc_i[BW+1:2]] != 2'b00)
          bht[bht_upd_pc_i[BW+1:2]] <= bht[bht_upd_pc_i[BW+1:2]] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count_o <= '0;
    end else if (flush_i) begin
      head    <= '0;
      tail    <= '0;
      count_o <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      unique case ({push, pop})
        2'b10:   count_o <= count_o + CW'(1);
        2'b01:   count_o <= count_o - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[tail] <= fetch_inst;
      q_pc[tail]   <= fpc;
      q_pred[tail] <= pred;
    end
  end

endmodule

// File: doc/stage_if_prefetch.md
STAGE_IF_PREFETCH -- requirements
Module: stage_if_prefetch

Interface
REQ-001 Parameter QDEPTH, default 4: instruction queue entries; power of two, 2..16.
REQ-002 Parameter BHT_NUM, default 128: 2-bit BHT entries; power of two.
REQ-003 Parameter PRED_EN, default 1: 1 enables branch/JAL prediction; 0 forces next pc = pc+4.
REQ-004 Parameter RESET_PC, default 32'h0: first fetch address after reset.
REQ-005 Ports, in the form name, direction, width, meaning:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush_i  in  1  redirect request.
- flush_addr_i  in  32  redirect target.
- bht_upd_i  in  1  resolved conditional branch.
- bht_upd_pc_i  in  32  pc of the resolved branch.
- bht_upd_taken_i  in  1  actual direction of the resolved branch.
- icache_raddr_o  out  32  icache lookup address.
- icache_hit_i  in  1  icache hit.
- icache_inst_i  in  32  icache data.
- icache_we_o  out  1  icache fill strobe.
- icache_waddr_o  out  32  icache fill address.
- icache_winst_o  out  32  icache fill data.
- mem_req_o  out  1  memory byte-fetch request.
- mem_a_o  out  32  byte address.
- mem_gnt_i  in  1  arbiter grant for the current address.
- mem_din_i  in  8  memory read byte.
- deq_i  in  1  consumer pops the queue head.
- valid_o  out  1  queue not empty.
- inst_o  out  32  head instruction.
- pc_o  out  32  head pc.
- pred_taken_o  out  1  head predicted taken.
- count_o  out  $clog2(QDEPTH)+1  occupancy.

Function
REQ-006 Fetch FSM states: IDLE, LOOKUP, MEM, DONE; fetch pc register fpc.
REQ-007 IDLE: when count_o < QDEPTH and flush_i=0, register icache_raddr_o<=fpc and go to LOOKUP.
REQ-008 LOOKUP hit: push {icache_inst_i, fpc, pred}, update fpc per REQ-012, go to IDLE.
REQ-009 LOOKUP miss: set mem_req_o=1, set mem_a_o=fpc, clear byte index k=0, go to MEM.
REQ-010 MEM protocol:
- a byte is accepted iff mem_gnt_i=1 in the cycle its address is on mem_a_o, and arrives on mem_din_i the next cycle;
- mem_a_o advances fpc+1, fpc+2, fpc+3 only on grant; without grant it holds the address;
- after fpc+3 is granted, mem_req_o drops and the FSM goes to DONE.
REQ-011 DONE, on byte 3 arrival:
- push the little-endian word {b3,b2,b1,b0};
- pulse icache_we_o for 1 cycle with icache_waddr_o=fpc and icache_winst_o=the word;
- update fpc per REQ-012 and go to IDLE.
REQ-012 Next-fpc rules:
- if PRED_EN=1, opcode 1100011 and BHT counter >= 2'b10: fpc+B-immediate, pred_taken=1;
- if PRED_EN=1 and opcode 1101111: fpc+J-immediate, pred_taken=1;
- otherwise: fpc+4, pred_taken=0.
REQ-013 Latency from IDLE-issue edge to valid_o with an empty queue: 2 cycles on a hit; 7 cycles on a miss with continuous grant.
REQ-014 BHT index is pc[$clog2(BHT_NUM)+1:2].
REQ-015 When bht_upd_i=1, the counter saturates toward 2'b11 if taken, toward 2'b00 if not.
REQ-016 A same-cycle lookup and update of one BHT entry: the lookup sees the old value.
REQ-017 Queue is a circular FIFO with wrapping pointers; head fields drive inst_o, pc_o and pred_taken_o.
REQ-018 Push and pop in the same cycle leave count_o unchanged.
REQ-019 deq_i while empty is ignored.
REQ-020 No fetch starts while count_o=QDEPTH, so a push never overflows.
REQ-021 Flush has highest priority and takes effect at the next edge:
- queue emptied, valid_o=0 and count_o=0;
- FSM goes to IDLE, fpc<=flush_addr_i, mem_req_o=0;
- in-flight bytes are discarded and no icache_we_o pulse occurs for the aborted fetch;
- deq_i in the same cycle is ignored.
REQ-022 A BHT update coinciding with a flush is still applied.

Reset
REQ-023 While rst=0, asynchronously:
- fpc=RESET_PC, FSM=IDLE, queue empty;
- all BHT entries=2'b01;
- every output 0.
REQ-024 Reset asserted mid-miss aborts the fetch with no icache write.
REQ-025 The first fetch issues at RESET_PC on the first edge after rst rises.

Verification
REQ-026 After reset, icache hits at 0x0 with inst 0x00000013 -> valid_o=1 with pc_o=0x0, then pc_o=0x4.
REQ-027 Miss at 0x10, bytes 13,05,00,00, continuous grant -> inst_o=0x00000513 at cycle 7; one icache_we_o pulse with waddr 0x10.
REQ-028 Grant withheld 3 cycles on byte 2 -> mem_a_o holds 0x12; same word assembled, 3 cycles later.
REQ-029 Scenario on QDEPTH=4:
- hits without deq_i -> count_o stops at 4 and no further icache_raddr_o change;
- one deq_i -> exactly one new fetch.
REQ-030 Branch 0xFE000EE3 at 0x20 with BHT entry trained to 2'b11 -> next pc_o=0x1C and pred_taken_o=1; with the entry at 2'b01 -> next pc_o=0x24.
REQ-031 flush_i to 0x100 during MEM byte 1 -> queue empty next cycle, no icache_we_o, next lookup at 0x100.
